// File: rtl/ni_packetizer_if.sv
// Flit-id encodings and the handshake bundle between the local core,
// the packetizer and the router's local input port.

`ifndef HEADER
`define HEADER 3'b001
`endif
`ifndef PAYLOAD
`define PAYLOAD 3'b010
`endif
`ifndef TAIL
`define TAIL 3'b100
`endif

interface ni_packetizer_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic              pkt_valid;
  logic              pkt_ready;
  logic [3:0]        pkt_dst;
  logic [LEN_W-1:0]  pkt_len;
  logic              dat_valid;
  logic              dat_ready;
  logic [DATA_W-1:0] dat_in;
  logic              flit_valid;
  logic [2:0]        flit_id;
  logic [3:0]        flit_dst;
  logic [DATA_W-1:0] flit_data;
  logic              credit_in;

  // master: the packetizer, which produces flits and the ready signals
  modport master (
    input  pkt_valid, pkt_dst, pkt_len, dat_valid, dat_in, credit_in,
    output pkt_ready, dat_ready, flit_valid, flit_id, flit_dst, flit_data
  );

  // slave: the core / router side that supplies requests, words and credits
  modport slave (
    output pkt_valid, pkt_dst, pkt_len, dat_valid, dat_in, credit_in,
    input  pkt_ready, dat_ready, flit_valid, flit_id, flit_dst, flit_data
  );
endinterface

// File: rtl/ni_packetizer.sv
// Network-interface transmit packetizer: turns a packet request plus a stream
// of payload words into HEADER / PAYLOAD / TAIL flits, paced by credits
// returned from the downstream input buffer.

module ni_packetizer #(
  parameter  int DATA_W    = 32,
  parameter  int LEN_W     = 4,
  parameter  int BUF_DEPTH = 4,
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       cur_addr_rst_i,
  ni_packetizer_if.master  bus,
  output logic [CNT_W-1:0] credit_cnt_o,
  output logic             credit_err_o
);

  typedef enum logic {
    IDLE,
    BODY
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        curAddr_q;
  logic [3:0]        dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  creditCnt_q, creditCnt_d;
  logic              creditErr_q, creditErr_d;
  logic              flitValid_q, flitValid_d;
  logic [2:0]        flitId_q, flitId_d;
  logic [3:0]        flitDst_q, flitDst_d;
  logic [DATA_W-1:0] flitData_q, flitData_d;

  logic              haveCredit;
  logic              pktFire;
  logic              datFire;
  logic              emit;
  logic [LEN_W-1:0]  lenEff;
  logic [DATA_W-1:0] hdrWord;

  // Ready depends only on registered state and credits, and drops during reset
  always_comb begin
    haveCredit    = (creditCnt_q != '0);
    bus.pkt_ready = (state_q == IDLE) && haveCredit && !rst;
    bus.dat_ready = (state_q == BODY) && haveCredit && !rst;
    pktFire       = bus.pkt_valid && bus.pkt_ready;
    datFire       = bus.dat_valid && bus.dat_ready;
    emit          = pktFire || datFire;
  end

  // Header word: dst in [3:0], own address in [7:4], length in [8 +: LEN_W]; a zero length means one word
  always_comb begin
    lenEff  = (bus.pkt_len == '0) ? LEN_W'(1) : bus.pkt_len;
    hdrWord = '0;
    hdrWord[3:0]       = bus.pkt_dst;
    hdrWord[7:4]       = curAddr_q;
    hdrWord[8 +: LEN_W] = lenEff;
  end

  // Packet sequencing: header on request, then payload words until the last becomes the tail
  always_comb begin
    state_d     = state_q;
    dst_d       = dst_q;
    rem_d       = rem_q;
    flitValid_d = 1'b0;
    flitId_d    = flitId_q;
    flitDst_d   = flitDst_q;
    flitData_d  = flitData_q;
    case (state_q)
      IDLE: begin
        if (pktFire) begin
          flitValid_d = 1'b1;
          flitId_d    = `HEADER;
          flitData_d  = hdrWord;
          flitDst_d   = bus.pkt_dst;
          dst_d       = bus.pkt_dst;
          rem_d       = lenEff;
          state_d     = BODY;
        end
      end
      BODY: begin
        if (datFire) begin
          flitValid_d = 1'b1;
          flitData_d  = bus.dat_in;
          flitDst_d   = dst_q;
          if (rem_q > LEN_W'(1)) begin
            flitId_d = `PAYLOAD;
            rem_d    = rem_q - LEN_W'(1);
          end else begin
            flitId_d = `TAIL;
            rem_d    = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit bookkeeping: a flit spends one, a returned credit restores one; an excess return is flagged
  always_comb begin
    creditCnt_d = creditCnt_q;
    creditErr_d = creditErr_q;
    if (emit && !bus.credit_in) begin
      creditCnt_d = creditCnt_q - CNT_W'(1);
    end else if (!emit && bus.credit_in) begin
      if (creditCnt_q == CNT_W'(BUF_DEPTH)) begin
        creditErr_d = 1'b1;
      end else begin
        creditCnt_d = creditCnt_q + CNT_W'(1);
      end
    end
  end

  // State and output registers; reset drops any packet in flight and captures the node address
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      curAddr_q   <= cur_addr_rst_i;
      dst_q       <= '0;
      rem_q       <= '0;
      creditCnt_q <= CNT_W'(BUF_DEPTH);
      creditErr_q <= 1'b0;
      flitValid_q <= 1'b0;
      flitId_q    <= '0;
      flitDst_q   <= '0;
      flitData_q  <= '0;
    end else begin
      state_q     <= state_d;
      dst_q       <= dst_d;
      rem_q       <= rem_d;
      creditCnt_q <= creditCnt_d;
      creditErr_q <= creditErr_d;
      flitValid_q <= flitValid_d;
      flitId_q    <= flitId_d;
      flitDst_q   <= flitDst_d;
      flitData_q  <= flitData_d;
    end
  end

  assign bus.flit_valid = flitValid_q;
  assign bus.flit_id    = flitId_q;
  assign bus.flit_dst   = flitDst_q;
  assign bus.flit_data  = flitData_q;
  assign credit_cnt_o   = creditCnt_q;
  assign credit_err_o   = creditErr_q;

endmodule

// File: tb/tb_ni_packetizer.sv
// Testbench for ni_packetizer: directed vector table, hand-written credit and
// reset sequences, then randomized traffic against a flit-list reference model.

module tb_ni_packetizer;

  localparam int DATA_W    = 32;
  localparam int LEN_W     = 4;
  localparam int BUF_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] curAddrRst;
  logic [2:0] creditCnt;
  logic       creditErr;

  int errors = 0;
  int checks = 0;

  ni_packetizer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  ni_packetizer #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cur_addr_rst_i(curAddrRst),
    .bus(bus),
    .credit_cnt_o(creditCnt),
    .credit_err_o(creditErr)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [3:0]  dst;
    logic [3:0]  len;
    logic        dv;
    logic [31:0] din;
    logic        ci;
    logic        eValid;
    logic [2:0]  eId;
    logic [31:0] eData;
    logic [3:0]  eDst;
    logic [2:0]  eCred;
    logic        eErr;
  } vec_t;

  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] data;
    logic [3:0]  dst;
  } flit_t;

  vec_t  vecs[8];
  flit_t toSend[$];

  // Drive one cycle of inputs on the falling edge
  task automatic applyStimulus(input logic pv, input logic [3:0] dst, input logic [3:0] len,
                               input logic dv, input logic [31:0] din, input logic ci);
    @(negedge clk);
    bus.pkt_valid = pv;
    bus.pkt_dst   = dst;
    bus.pkt_len   = len;
    bus.dat_valid = dv;
    bus.dat_in    = din;
    bus.credit_in = ci;
  endtask

  // Advance past the next rising edge so registered outputs have settled
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value with the value the bench expects
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkFlit(input string tag, input logic v, input logic [2:0] id,
                           input logic [31:0] data, input logic [3:0] dst, input logic [2:0] cred);
    checkOutput({tag, " flit_valid"}, bus.flit_valid, v);
    checkOutput({tag, " flit_id"},    bus.flit_id, id);
    checkOutput({tag, " flit_data"},  bus.flit_data, data);
    checkOutput({tag, " flit_dst"},   bus.flit_dst, dst);
    checkOutput({tag, " credit_cnt"}, creditCnt, cred);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    stepCycle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] reqDst;
    logic [3:0] reqLen;
    int         mc;
    int         n;
    logic       headFront;
    logic       dataFront;
    logic       expPr;
    logic       expDr;
    logic       fire;
    flit_t      exp;
    flit_t      last;

    rst            = 1'b1;
    curAddrRst     = 4'h5;
    bus.pkt_valid  = 1'b0;
    bus.pkt_dst    = '0;
    bus.pkt_len    = '0;
    bus.dat_valid  = 1'b0;
    bus.dat_in     = '0;
    bus.credit_in  = 1'b0;

    // Reset state
    stepCycle();
    checkFlit("reset", 1'b0, 3'd0, 32'h0, 4'h0, 3'd4);
    checkOutput("reset credit_err", creditErr, 1'b0);
    checkOutput("reset pkt_ready", bus.pkt_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post-reset pkt_ready", bus.pkt_ready, 1'b1);
    checkOutput("post-reset dat_ready", bus.dat_ready, 1'b0);

    // Vector table: 3-word packet with credits returned, zero-length packet, idle credit overflow
    vecs[0] = '{1'b1, 4'hA, 4'd3, 1'b0, 32'h0,    1'b0, 1'b1, `HEADER,  32'h35A,  4'hA, 3'd3, 1'b0};
    vecs[1] = '{1'b0, 4'hA, 4'd3, 1'b1, 32'h11,   1'b1, 1'b1, `PAYLOAD, 32'h11,   4'hA, 3'd3, 1'b0};
    vecs[2] = '{1'b0, 4'hA, 4'd3, 1'b1, 32'h22,   1'b1, 1'b1, `PAYLOAD, 32'h22,   4'hA, 3'd3, 1'b0};
    vecs[3] = '{1'b0, 4'hA, 4'd3, 1'b1, 32'h33,   1'b1, 1'b1, `TAIL,    32'h33,   4'hA, 3'd3, 1'b0};
    vecs[4] = '{1'b1, 4'h5, 4'd0, 1'b0, 32'h0,    1'b1, 1'b1, `HEADER,  32'h155,  4'h5, 3'd3, 1'b0};
    vecs[5] = '{1'b0, 4'h5, 4'd0, 1'b1, 32'hDEAD, 1'b1, 1'b1, `TAIL,    32'hDEAD, 4'h5, 3'd3, 1'b0};
    vecs[6] = '{1'b0, 4'h5, 4'd0, 1'b0, 32'h0,    1'b1, 1'b0, `TAIL,    32'hDEAD, 4'h5, 3'd4, 1'b0};
    vecs[7] = '{1'b0, 4'h5, 4'd0, 1'b0, 32'h0,    1'b1, 1'b0, `TAIL,    32'hDEAD, 4'h5, 3'd4, 1'b1};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].pv, vecs[i].dst, vecs[i].len, vecs[i].dv, vecs[i].din, vecs[i].ci);
      stepCycle();
      checkFlit($sformatf("vec%0d", i), vecs[i].eValid, vecs[i].eId, vecs[i].eData,
                vecs[i].eDst, vecs[i].eCred);
      checkOutput($sformatf("vec%0d credit_err", i), creditErr, vecs[i].eErr);
    end
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    stepCycle();
    checkOutput("sticky credit_err", creditErr, 1'b1);
    doReset();
    #1;
    checkOutput("credit_err cleared", creditErr, 1'b0);

    // Credit exhaustion: 6-word packet with no credits returned stops after 4 flits
    applyStimulus(1'b1, 4'h3, 4'd6, 1'b0, 32'h0, 1'b0);
    stepCycle();
    checkFlit("nocred hdr", 1'b1, `HEADER, 32'h653, 4'h3, 3'd3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'h3, 4'd6, 1'b1, 32'h100 + 32'(i), 1'b0);
      stepCycle();
      checkFlit($sformatf("nocred p%0d", i), 1'b1, `PAYLOAD, 32'h100 + 32'(i), 4'h3, 3'(2 - i));
    end
    checkOutput("nocred dat_ready", bus.dat_ready, 1'b0);
    applyStimulus(1'b0, 4'h3, 4'd6, 1'b1, 32'h103, 1'b0);
    stepCycle();
    checkFlit("nocred stall", 1'b0, `PAYLOAD, 32'h102, 4'h3, 3'd0);
    applyStimulus(1'b0, 4'h3, 4'd6, 1'b1, 32'h103, 1'b1);
    stepCycle();
    checkFlit("nocred pulse", 1'b0, `PAYLOAD, 32'h102, 4'h3, 3'd1);
    checkOutput("nocred dat_ready back", bus.dat_ready, 1'b1);
    applyStimulus(1'b0, 4'h3, 4'd6, 1'b1, 32'h103, 1'b0);
    stepCycle();
    checkFlit("nocred one", 1'b1, `PAYLOAD, 32'h103, 4'h3, 3'd0);
    applyStimulus(1'b0, 4'h3, 4'd6, 1'b1, 32'h104, 1'b0);
    stepCycle();
    checkFlit("nocred only one", 1'b0, `PAYLOAD, 32'h103, 4'h3, 3'd0);
    doReset();

    // Reset in the middle of a 5-word packet, then a fresh packet
    applyStimulus(1'b1, 4'h6, 4'd5, 1'b0, 32'h0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 4'h6, 4'd5, 1'b1, 32'h201, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 4'h6, 4'd5, 1'b1, 32'h202, 1'b0);
    stepCycle();
    checkFlit("mid p2", 1'b1, `PAYLOAD, 32'h202, 4'h6, 3'd1);
    applyStimulus(1'b0, 4'h6, 4'd5, 1'b1, 32'h203, 1'b0);
    rst = 1'b1;
    stepCycle();
    checkFlit("mid reset", 1'b0, 3'd0, 32'h0, 4'h0, 3'd4);
    applyStimulus(1'b1, 4'h9, 4'd1, 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    stepCycle();
    checkFlit("mid new hdr", 1'b1, `HEADER, 32'h159, 4'h9, 3'd3);
    doReset();

    // Randomized traffic against a queue of flits each packet must produce
    mc     = BUF_DEPTH;
    last   = '0;
    reqDst = '0;
    reqLen = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (toSend.size() == 0 && $urandom_range(0, 2) == 0) begin
        reqDst = 4'($urandom_range(0, 15));
        reqLen = 4'($urandom_range(0, 15));
        n = (reqLen == 0) ? 1 : int'(reqLen);
        toSend.push_back('{`HEADER, (32'(n) << 8) | (32'(curAddrRst) << 4) | 32'(reqDst), reqDst});
        for (int k = 0; k < n; k++)
          toSend.push_back('{(k == n - 1) ? `TAIL : `PAYLOAD, 32'($urandom), reqDst});
      end
      headFront = (toSend.size() > 0) && (toSend[0].id == `HEADER);
      dataFront = (toSend.size() > 0) && !headFront;
      bus.pkt_valid = headFront ? 1'b1 : (dataFront && ($urandom_range(0, 3) == 0));
      bus.pkt_dst   = reqDst;
      bus.pkt_len   = reqLen;
      bus.dat_valid = dataFront ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      bus.dat_in    = dataFront ? toSend[0].data : 32'($urandom);
      bus.credit_in = (mc < BUF_DEPTH) && ($urandom_range(0, 1) == 1);
      #4;
      expPr = !dataFront && (mc > 0);
      expDr = dataFront && (mc > 0);
      checkOutput("rand pkt_ready", bus.pkt_ready, expPr);
      checkOutput("rand dat_ready", bus.dat_ready, expDr);
      fire = (bus.pkt_valid && expPr && headFront) || (bus.dat_valid && expDr);
      if (fire) begin
        exp  = toSend.pop_front();
        last = exp;
      end
      mc = mc + int'(bus.credit_in) - int'(fire);
      stepCycle();
      checkFlit("rand", fire, last.id, last.data, last.dst, 3'(mc));
      checkOutput("rand credit_err", creditErr, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ni_packetizer.md
# ni_packetizer

Network-interface transmit block that turns local packet requests plus a payload word stream into the HEADER/PAYLOAD/TAIL flit sequence the router input port (FIFO + LBDR) consumes. It stamps the flit id, destination address and a header word, and paces injection with credit-based flow control against the downstream input buffer. It sits between the local core and the router's local input port.

## Interface

- DATA_W, 32, flit data width; must be >= 8+LEN_W
- LEN_W, 4, width of packet length field (payload words per packet)
- BUF_DEPTH, 4, downstream input-buffer depth = initial credits
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- cur_addr_rst  in  4  own node address {y[1:0],x[1:0]}, latched every cycle rst is high
- pkt_valid  in  1  packet request valid
- pkt_ready  out  1  request accepted when pkt_valid & pkt_ready
- pkt_dst  in  4  destination address {y,x}
- pkt_len  in  LEN_W  payload word count N; 0 treated as 1
- dat_valid  in  1  payload word valid
- dat_ready  out  1  payload word accepted when dat_valid & dat_ready
- dat_in  in  DATA_W  payload word
- flit_valid  out  1  one-cycle write strobe into downstream buffer
- flit_id  out  3  `HEADER / `PAYLOAD / `TAIL from the shared parameters include
- flit_dst  out  4  dst_addr sideband for LBDR; held for whole packet and until next header
- flit_data  out  DATA_W  flit payload
- credit_in  in  1  one-cycle pulse: downstream freed one buffer slot
- credit_cnt  out  $clog2(BUF_DEPTH+1)  current credits
- credit_err  out  1  sticky credit-overflow flag

## Operation

- States: IDLE, BODY. Registers: cur_addr, dst, rem (LEN_W), credit_cnt.
- pkt_ready = (state==IDLE) & (credit_cnt>0) & ~rst. dat_ready = (state==BODY) & (credit_cnt>0) & ~rst. Both combinational from registered state.
- IDLE, request accepted: emit header flit (flit_id=`HEADER, flit_data[3:0]=pkt_dst, [7:4]=cur_addr, [8+LEN_W-1:8]=N, upper bits 0), latch dst, rem<=N, -> BODY.
- BODY, word accepted: rem>1 -> emit `PAYLOAD with dat_in, rem<=rem-1; rem==1 -> emit `TAIL with dat_in, -> IDLE.
- A packet of N words = 1 header + (N-1) payload + 1 tail; N=1 gives HEADER, TAIL.
- flit_valid=1 only on an emitting edge; otherwise 0 while flit_id/flit_data/flit_dst hold last values.
- Credits: each emitted flit -1, each credit_in +1; both in same cycle -> unchanged. No flit is emitted with credit_cnt==0 (ready deasserted).
- credit_in with credit_cnt==BUF_DEPTH and no flit emitted: count saturates, credit_err<=1 (stays until rst).
- Destination equal to own address is sent normally (LBDR selects Lport).

## Timing

- All outputs registered except pkt_ready/dat_ready.
- Reset (rst high at edge): state IDLE, rem 0, credit_cnt BUF_DEPTH, credit_err 0, flit_valid 0, flit_id 0, flit_dst 0, flit_data 0; cur_addr<=cur_addr_rst. Reset mid-packet abandons the packet, no tail emitted.
- Request accepted in cycle c -> header visible cycle c+1. Word k accepted in cycle t -> its flit visible t+1.
- Continuous dat_valid and enough credits: words in cycles c+1..c+N, tail visible c+N+1, pkt_ready high again in c+N+1, next header c+N+2: one flit per cycle, no bubble between packets.
- credit_in in cycle t reflected in credit_cnt at t+1; a freed slot can be used from t+1.
- dat_valid low in BODY: stall, no flit, state held.

## Test plan

- Reset with cur_addr_rst=5: outputs all 0, credit_cnt=4, pkt_ready=1 next cycle.
- pkt_dst=0xA, pkt_len=3, dat 0x11,0x22,0x33 continuous, credit_in returned each cycle: flits HEADER(data=0x35A), PAYLOAD 0x11, PAYLOAD 0x22, TAIL 0x33 on 4 consecutive cycles, flit_dst=0xA throughout.
- pkt_len=0: exactly HEADER(len field 1) then TAIL with the single word.
- No credit_in, pkt_len=6: 4 flits sent, credit_cnt=0, dat_ready low; one credit_in pulse -> exactly one further flit next cycle.
- credit_in and flit emission in same cycle: credit_cnt unchanged; credit_in at credit_cnt=4 while idle -> credit_cnt stays 4, credit_err=1 until rst.
- rst asserted after second payload of 5-word packet: next cycle state IDLE, credit_cnt=4, flit_valid=0; new packet starts with HEADER.
